// File: rtl/coh_resp_port.sv
// coh_resp_port: responder end of the DMA coherence-master protocol.
// Serialises requester ownership pulses by fixed priority into cache
// snoops and returns each MESI answer as a one-cycle grant pulse.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   up_lock[NPORT]    requester i keeps ownership while high
//   up_rqst/trsc/addr per-port request pulse (id), code, block address
//   up_resp/up_mesi   per-port one-cycle grant echo and MESI answer
//   dn_lock           busy or owned
//   dn_rqst/trsc/addr snoop pulse (RID) and held snoop payload
//   dn_resp/dn_mesi   cache answer (dn_resp==RID) and MESI state
//   err               sticky protocol-violation flag
module coh_resp_port #(
  parameter int         NPORT = 2,
  parameter logic [7:0] RID   = 8'd8,
  parameter int         TMO   = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NPORT-1:0]      up_lock,
  input  logic [8*NPORT-1:0]    up_rqst,
  input  logic [8*NPORT-1:0]    up_trsc,
  input  logic [64*NPORT-1:0]   up_addr,
  output logic [8*NPORT-1:0]    up_resp,
  output logic [8*NPORT-1:0]    up_mesi,
  output logic                  dn_lock,
  output logic [7:0]            dn_rqst,
  output logic [7:0]            dn_trsc,
  output logic [63:0]           dn_addr,
  input  logic [7:0]            dn_resp,
  input  logic [7:0]            dn_mesi,
  output logic                  err
);

  localparam int SW = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam int CW = $clog2(TMO);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } st_t;

  st_t st;
  st_t st_nx;

  logic [SW-1:0]    sel;
  logic [SW-1:0]    pick;
  logic [CW-1:0]    cnt;
  logic [7:0]       mesi_q;
  logic             own_v;
  logic [SW-1:0]    own_p;
  logic             hit;

  logic [NPORT-1:0] full;
  logic [NPORT-1:0] nw;
  logic [NPORT-1:0] fr;
  logic [NPORT-1:0] drop;
  logic [NPORT-1:0] elig;

  logic [7:0]       s_id   [NPORT];
  logic [7:0]       s_trsc [NPORT];
  logic [63:0]      s_addr [NPORT];

  // RID is nonzero, so an idle (zero) dn_resp never matches.
  assign hit = (dn_resp == RID);

  // fr: slot being released this cycle; a pulse on it may refill it.
  always_comb begin
    nw   = '0;
    fr   = '0;
    drop = '0;
    elig = '0;
    pick = '0;
    for (int i = 0; i < NPORT; i++) begin
      nw[i]   = |up_rqst[i*8 +: 8];
      fr[i]   = (st == RESP) && (sel == SW'(i));
      drop[i] = nw[i] && full[i] && !fr[i];
      elig[i] = full[i] &&
                (!own_v || (own_p == SW'(i)));
    end
    for (int i = NPORT - 1; i >= 0; i--) begin
      if (elig[i]) pick = SW'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) st <= IDLE;
    else     st <= st_nx;
  end

  always_comb begin
    st_nx = st;
    unique case (st)
      IDLE:  if (|elig) st_nx = ISSUE;
      ISSUE: st_nx = hit ? RESP : WAIT;
      WAIT: begin
        if (hit)
          st_nx = RESP;
        else if (cnt == CW'(TMO - 1))
          st_nx = ISSUE;
      end
      RESP:  st_nx = IDLE;
    endcase
  end

  always_comb begin
    up_resp = '0;
    up_mesi = '0;
    dn_rqst = '0;
    dn_trsc = '0;
    dn_addr = '0;
    unique case (st)
      IDLE: ;
      ISSUE: begin
        dn_rqst = RID;
        dn_trsc = s_trsc[sel];
        dn_addr = s_addr[sel];
      end
      WAIT: begin
        dn_trsc = s_trsc[sel];
        dn_addr = s_addr[sel];
      end
      RESP: begin
        for (int i = 0; i < NPORT; i++) begin
          if (sel == SW'(i)) begin
            up_resp[i*8 +: 8] = s_id[i];
            up_mesi[i*8 +: 8] = mesi_q;
          end
        end
      end
    endcase
  end

  assign dn_lock = (|full) || own_v || (st != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      sel    <= '0;
      cnt    <= '0;
      mesi_q <= '0;
      own_v  <= 1'b0;
      own_p  <= '0;
      err    <= 1'b0;
      full   <= '0;
      for (int i = 0; i < NPORT; i++) begin
        s_id[i]   <= '0;
        s_trsc[i] <= '0;
        s_addr[i] <= '0;
      end
    end else begin
      if (st == IDLE && |elig)
        sel <= pick;

      if (st == ISSUE)
        cnt <= '0;
      else if (st == WAIT)
        cnt <= cnt + CW'(1);

      if ((st == ISSUE || st == WAIT) && hit)
        mesi_q <= dn_mesi;

      // A fresh grant to a locked port wins over the lock-drop clear.
      if (st == RESP && up_lock[sel]) begin
        own_v <= 1'b1;
        own_p <= sel;
      end else if (own_v && !up_lock[own_p]) begin
        own_v <= 1'b0;
      end

      if (|drop)
        err <= 1'b1;

      for (int i = 0; i < NPORT; i++) begin
        if (nw[i] && !drop[i]) begin
          full[i]   <= 1'b1;
          s_id[i]   <= up_rqst[i*8 +: 8];
          s_trsc[i] <= up_trsc[i*8 +: 8];
          s_addr[i] <= up_addr[i*64 +: 64];
        end else if (fr[i]) begin
          full[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_coh_resp_port.sv
// tb_coh_resp_port: directed bench for coh_resp_port with a
// transaction-level reference model and a small cache emulator.
module tb_coh_resp_port;

  localparam int         NP  = 2;
  localparam logic [7:0] RID = 8'd8;
  localparam int         TMO = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NP-1:0]        up_lock;
  logic [8*NP-1:0]      up_rqst;
  logic [8*NP-1:0]      up_trsc;
  logic [64*NP-1:0]     up_addr;
  logic [8*NP-1:0]      up_resp;
  logic [8*NP-1:0]      up_mesi;
  logic                 dn_lock;
  logic [7:0]           dn_rqst;
  logic [7:0]           dn_trsc;
  logic [63:0]          dn_addr;
  logic [7:0]           dn_resp;
  logic [7:0]           dn_mesi;
  logic                 err;

  always #5 clk = ~clk;

  coh_resp_port #(
    .NPORT (NP),
    .RID   (RID),
    .TMO   (TMO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .up_lock (up_lock),
    .up_rqst (up_rqst),
    .up_trsc (up_trsc),
    .up_addr (up_addr),
    .up_resp (up_resp),
    .up_mesi (up_mesi),
    .dn_lock (dn_lock),
    .dn_rqst (dn_rqst),
    .dn_trsc (dn_trsc),
    .dn_addr (dn_addr),
    .dn_resp (dn_resp),
    .dn_mesi (dn_mesi),
    .err     (err)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model: pending table, owner, and the transaction in
  // flight measured by its age since the first snoop pulse.
  bit          m_pv [NP];
  logic [7:0]  m_id [NP];
  logic [7:0]  m_tr [NP];
  logic [63:0] m_ad [NP];
  bit          m_ov;
  int          m_op;
  bit          m_ev;
  int          m_cur;
  int          m_age;
  bit          m_ans;
  logic [7:0]  m_mesi;

  // Cache emulator: mode 0 silent, 1 answers every pulse at once,
  // 2 answers c_dly cycles after the c_nth pulse.
  int          c_mode;
  int          c_nth;
  int          c_dly;
  int          c_cnt;
  int          c_since;
  bit          c_junk;
  bit          c_stray;
  logic [7:0]  c_mesi;

  int          rq_q  [$];
  int          r0_c  [$];
  int          r1_c  [$];
  logic [7:0]  r0_id [$];
  logic [7:0]  r0_m  [$];
  logic [7:0]  r1_id [$];
  logic [7:0]  r1_m  [$];

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h want=%h",
               nm, cyc, act, exp);
    end
  endtask

  task automatic model_update();
    int fr;
    bit opv;
    int opp;
    bit ppv [NP];
    if (rst) begin
      for (int i = 0; i < NP; i++) m_pv[i] = 1'b0;
      m_ov   = 1'b0;
      m_op   = 0;
      m_ev   = 1'b0;
      m_cur  = -1;
      m_age  = 0;
      m_ans  = 1'b0;
      m_mesi = '0;
    end else begin
      fr  = m_ans ? m_cur : -1;
      opv = m_ov;
      opp = m_op;
      for (int i = 0; i < NP; i++) ppv[i] = m_pv[i];
      if (m_ans) begin
        m_cur = -1;
        m_ans = 1'b0;
      end else if (m_cur >= 0) begin
        if (dn_resp == RID) begin
          m_ans  = 1'b1;
          m_mesi = dn_mesi;
        end else begin
          m_age++;
        end
      end else begin
        for (int i = NP - 1; i >= 0; i--)
          if (ppv[i] && (!opv || opp == i)) m_cur = i;
        m_age = 0;
      end
      if (fr >= 0 && up_lock[fr]) begin
        m_ov = 1'b1;
        m_op = fr;
      end else if (opv && !up_lock[opp]) begin
        m_ov = 1'b0;
      end
      for (int i = 0; i < NP; i++) begin
        if (up_rqst[i*8 +: 8] != 0) begin
          if (ppv[i] && fr != i) begin
            m_ev = 1'b1;
          end else begin
            m_pv[i] = 1'b1;
            m_id[i] = up_rqst[i*8 +: 8];
            m_tr[i] = up_trsc[i*8 +: 8];
            m_ad[i] = up_addr[i*64 +: 64];
          end
        end else if (fr == i) begin
          m_pv[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [8*NP-1:0] er;
    logic [8*NP-1:0] em;
    logic [7:0]      erq;
    logic [7:0]      etr;
    logic [63:0]     ead;
    logic            el;
    er  = '0;
    em  = '0;
    erq = '0;
    etr = '0;
    ead = '0;
    if (m_cur >= 0 && m_ans) begin
      er[m_cur*8 +: 8] = m_id[m_cur];
      em[m_cur*8 +: 8] = m_mesi;
    end
    if (m_cur >= 0 && !m_ans) begin
      etr = m_tr[m_cur];
      ead = m_ad[m_cur];
      if (m_age % (TMO + 1) == 0) erq = RID;
    end
    el = m_ov || (m_cur >= 0);
    for (int i = 0; i < NP; i++) el = el || m_pv[i];
    chk("up_resp", up_resp, er);
    chk("up_mesi", up_mesi, em);
    chk("dn_rqst", dn_rqst, erq);
    chk("dn_trsc", dn_trsc, etr);
    chk("dn_addr", dn_addr, ead);
    chk("dn_lock", dn_lock, el);
    chk("err", err, m_ev);
  endtask

  task automatic cache_drive();
    bit ans;
    ans     = 1'b0;
    dn_resp = '0;
    dn_mesi = '0;
    if (dn_rqst == RID) begin
      c_cnt++;
      c_since = 0;
    end else begin
      c_since++;
    end
    if (c_mode == 1)
      ans = (dn_rqst == RID);
    else if (c_mode == 2)
      ans = (c_cnt == c_nth) && (c_since == c_dly);
    if (ans) begin
      dn_resp = RID;
      dn_mesi = c_mesi;
    end else if (c_stray) begin
      dn_resp = RID;
      dn_mesi = 8'hAA;
    end else if (c_junk) begin
      dn_resp = RID ^ 8'h01;
      dn_mesi = 8'hEE;
    end
    c_stray = 1'b0;
  endtask

  task automatic cache_cfg(int md, int nth, int dly,
                           logic [7:0] ms);
    c_mode  = md;
    c_nth   = nth;
    c_dly   = dly;
    c_mesi  = ms;
    c_cnt   = 0;
    c_since = 1000;
    c_junk  = 1'b0;
    c_stray = 1'b0;
  endtask

  task automatic log_outputs();
    if (dn_rqst != 0) rq_q.push_back(cyc);
    if (up_resp[7:0] != 0) begin
      r0_c.push_back(cyc);
      r0_id.push_back(up_resp[7:0]);
      r0_m.push_back(up_mesi[7:0]);
    end
    if (up_resp[15:8] != 0) begin
      r1_c.push_back(cyc);
      r1_id.push_back(up_resp[15:8]);
      r1_m.push_back(up_mesi[15:8]);
    end
  endtask

  // One clock: model and DUT advance on the edge, the cache reacts
  // just after it, outputs are compared on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_update();
    cyc++;
    #1;
    up_rqst = '0;
    cache_drive();
    @(negedge clk);
    compare_all();
    log_outputs();
  endtask

  task automatic pulse(int p, logic [7:0] id, logic [7:0] tr,
                       logic [63:0] ad);
    up_rqst[p*8 +: 8]  = id;
    up_trsc[p*8 +: 8]  = tr;
    up_addr[p*64 +: 64] = ad;
  endtask

  initial begin
    int c;
    int d;
    int n0;
    int n1;
    int n2;
    rst     = 1'b1;
    up_lock = '0;
    up_rqst = '0;
    up_trsc = '0;
    up_addr = '0;
    dn_resp = '0;
    dn_mesi = '0;
    m_cur   = -1;
    cache_cfg(0, 0, 0, 8'h00);
    repeat (3) tick();
    chk("rst_dn_lock", dn_lock, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_up_resp", up_resp, '0);
    rst = 1'b0;
    tick();

    // single request, same-cycle answer
    cache_cfg(1, 0, 0, 8'd2);
    n0 = rq_q.size();
    n1 = r0_c.size();
    pulse(0, 8'h01, 8'h11, 64'h8000_0040);
    c = cyc;
    repeat (6) tick();
    chk("t1_nrq", rq_q.size() - n0, 1);
    chk("t1_rq_at", (rq_q.size() > n0) ? rq_q[n0] : -1, c + 2);
    chk("t1_nresp", r0_c.size() - n1, 1);
    chk("t1_resp_at", (r0_c.size() > n1) ? r0_c[n1] : -1, c + 3);
    chk("t1_id", (r0_id.size() > n1) ? r0_id[n1] : 8'h00, 8'h01);
    chk("t1_mesi", (r0_m.size() > n1) ? r0_m[n1] : 8'h00, 8'h02);

    // answer arrives in WAIT, four cycles after the pulse
    cache_cfg(2, 1, 4, 8'd3);
    n2 = r1_c.size();
    pulse(1, 8'h5A, 8'h22, 64'hDEAD_BEEF_0000_1000);
    c = cyc;
    repeat (10) tick();
    chk("t1b_nresp", r1_c.size() - n2, 1);
    chk("t1b_resp_at", (r1_c.size() > n2) ? r1_c[n2] : -1, c + 7);
    chk("t1b_mesi", (r1_m.size() > n2) ? r1_m[n2] : 8'h00, 8'h03);

    // priority: both ports in the same cycle
    cache_cfg(1, 0, 0, 8'd1);
    n1 = r0_c.size();
    n2 = r1_c.size();
    pulse(0, 8'h21, 8'h01, 64'h0000_0000_0000_1000);
    pulse(1, 8'h42, 8'h02, 64'h0000_0000_0000_2000);
    c = cyc;
    repeat (10) tick();
    chk("t2_p0_at", (r0_c.size() > n1) ? r0_c[n1] : -1, c + 3);
    chk("t2_p1_gap_ge3",
        (r1_c.size() > n2 && r0_c.size() > n1) ?
        (r1_c[n2] - r0_c[n1] >= 3) : 1'b0, 1'b1);
    chk("t2_p1_id", (r1_id.size() > n2) ? r1_id[n2] : 8'h00, 8'h42);

    // lock: port1 owns, port0 waits for the lock to fall
    cache_cfg(1, 0, 0, 8'd4);
    n0 = rq_q.size();
    n1 = r0_c.size();
    up_lock[1] = 1'b1;
    pulse(1, 8'h05, 8'h03, 64'h0000_0000_0000_3000);
    repeat (2) tick();
    pulse(0, 8'h06, 8'h04, 64'h0000_0000_0000_4000);
    repeat (8) tick();
    chk("t3_blocked_rq", rq_q.size() - n0, 1);
    chk("t3_blocked_resp", r0_c.size() - n1, 0);
    up_lock[1] = 1'b0;
    d = cyc;
    repeat (5) tick();
    chk("t3_rq_at", (rq_q.size() > n0 + 1) ? rq_q[n0+1] : -1, d + 2);
    chk("t3_resp_at", (r0_c.size() > n1) ? r0_c[n1] : -1, d + 3);

    // timeout: stray RID in IDLE ignored, answer on third pulse
    cache_cfg(2, 3, 0, 8'd1);
    c_junk  = 1'b1;
    c_stray = 1'b1;
    tick();
    n0 = rq_q.size();
    n2 = r1_c.size();
    pulse(1, 8'h77, 8'h03, 64'h1234_5678_9ABC_DEF0);
    c = cyc;
    repeat (26) tick();
    chk("t4_nrq", rq_q.size() - n0, 3);
    chk("t4_rq1_at", (rq_q.size() > n0) ? rq_q[n0] : -1, c + 2);
    chk("t4_rq2_at", (rq_q.size() > n0 + 1) ? rq_q[n0+1] : -1, c + 11);
    chk("t4_rq3_at", (rq_q.size() > n0 + 2) ? rq_q[n0+2] : -1, c + 20);
    chk("t4_nresp", r1_c.size() - n2, 1);
    chk("t4_resp_at", (r1_c.size() > n2) ? r1_c[n2] : -1, c + 21);

    // violation: pulses while full and while being served
    chk("t5_err_pre", err, 1'b0);
    cache_cfg(1, 0, 0, 8'd3);
    n1 = r0_c.size();
    pulse(0, 8'h03, 8'h05, 64'h0000_0000_0000_5000);
    tick();
    pulse(0, 8'h04, 8'h06, 64'h0000_0000_0000_6000);
    tick();
    pulse(0, 8'h44, 8'h07, 64'h0000_0000_0000_7000);
    repeat (6) tick();
    chk("t5_err", err, 1'b1);
    chk("t5_nresp", r0_c.size() - n1, 1);
    chk("t5_id", (r0_id.size() > n1) ? r0_id[n1] : 8'h00, 8'h03);

    // refill on the RESP cycle of the same port
    cache_cfg(1, 0, 0, 8'd2);
    n1 = r0_c.size();
    pulse(0, 8'h0A, 8'h08, 64'h0000_0000_0000_8000);
    c = cyc;
    repeat (3) tick();
    pulse(0, 8'h0B, 8'h09, 64'h0000_0000_0000_9000);
    repeat (6) tick();
    chk("t6_nresp", r0_c.size() - n1, 2);
    chk("t6_a_at", (r0_c.size() > n1) ? r0_c[n1] : -1, c + 3);
    chk("t6_b_at", (r0_c.size() > n1 + 1) ? r0_c[n1+1] : -1, c + 6);
    chk("t6_b_id", (r0_id.size() > n1 + 1) ? r0_id[n1+1] : 8'h00, 8'h0B);

    // reset while waiting on a silent cache
    cache_cfg(0, 0, 0, 8'd0);
    n1 = r0_c.size();
    pulse(0, 8'h0C, 8'h0A, 64'h0000_0000_0000_A000);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (15) tick();
    chk("t7_nresp", r0_c.size() - n1, 0);
    chk("t7_dn_lock", dn_lock, 1'b0);
    chk("t7_err", err, 1'b0);
    chk("t7_dn_trsc", dn_trsc, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
